md5_engine_scheduler: RTL and testbench
=======================================

// Module: md5_engine_scheduler
// PURPOSE
//  Shares one command/byte stream among NUM_ENG char_buff+md5 engines. Each job (start, byte
//  count, bytes) is dispatched round-robin to an idle engine. Engines run concurrently. The first
//  match is latched as a sticky result for the command layer to read back.
//  Sits between the command parser and the engine array.
// PARAMETERS
//  NUM_ENG   4   number of engines (2..16); ENG_W = $clog2(NUM_ENG) is a localparam
// PORTS
//  clk                  in   1          system clock
//  reset                in   1          synchronous, active-high
//  job_start            in   1          1-cycle pulse: new job; honoured only when job_ready=1
//  job_num_bytes        in   16         byte count of job, sampled with job_start
//  job_data             in   8          job byte
//  job_data_valid       in   1          job_data qualifier
//  job_ready            out  1          scheduler in IDLE and at least one engine idle
//  job_loaded           out  1          1-cycle pulse: all bytes of current job forwarded
//  all_idle             out  1          no engine busy and scheduler in IDLE
//  res_valid            out  1          sticky: a match has been latched
//  res_engine           out  ENG_W      index of matching engine
//  res_byte_pos         out  16         byte position from matching engine
//  res_char             out  8          eng_match_char of res_engine (combinational mux)
//  res_char_next        in   1          advance matched-string read; routed to res_engine only
//  res_clear            in   1          clear sticky result
//  eng_start            out  NUM_ENG    per-engine start pulse
//  eng_num_bytes        out  16         registered job byte count (shared)
//  eng_data             out  8          registered job_data (broadcast)
//  eng_data_valid       out  NUM_ENG    per-engine data strobe
//  eng_done             in   NUM_ENG    per-engine 1-cycle done pulse
//  eng_match            in   NUM_ENG    per-engine match flag, valid with eng_done
//  eng_byte_pos         in   16*NUM_ENG packed positions; engine i at [16*i+:16]
//  eng_match_char       in   8*NUM_ENG  packed match chars; engine i at [8*i+:8]
//  eng_match_char_next  out  NUM_ENG    per-engine read advance
//  led                  out  NUM_ENG    busy vector (debug)
// BEHAVIOUR
//  Reset: state=IDLE. rr_ptr=0. busy=0. count=0. All outputs 0: eng_*, job_loaded, res_*.
//   job_ready=1 one cycle after reset deasserts.
//  FSM IDLE: if job_start & job_ready (cycle t):
//   - sel = first idle engine searching rr_ptr, rr_ptr+1, ... (mod NUM_ENG).
//   - At t+1: eng_start[sel]=1 (1 cycle), busy[sel]=1, eng_num_bytes=job_num_bytes,
//     rr_ptr=sel+1 (wraps NUM_ENG-1 -> 0), count=0, state=STREAM.
//   - If num_bytes==0, go to LOADED instead of STREAM.
//   - job_start while job_ready=0 is ignored (no state change).
//  FSM STREAM: each job_data_valid at t yields eng_data=job_data and eng_data_valid[sel]=1 at t+1
//   (other bits 0); count++. When count==num_bytes -> LOADED. Valids arriving in LOADED are
//   dropped.
//  FSM LOADED: job_loaded=1 for exactly one cycle -> IDLE.
//  busy[i] clears on eng_done[i]. eng_done on a non-busy engine is ignored.
//   eng_start and eng_done on the same engine in the same cycle: busy stays 1.
//  Result latch: on any eng_done[i]&eng_match[i] while res_valid=0 (or res_clear=1):
//   - latch res_engine=i and res_byte_pos; set res_valid.
//   - Simultaneous matches: lowest index wins.
//   - res_clear with no new match -> res_valid=0. res_clear + new match same cycle -> new match
//     latched.
//   - Matches while res_valid=1 (no clear) are discarded.
//  eng_match_char_next[res_engine] = res_char_next & res_valid (combinational); other bits 0.
//  job_ready = (state==IDLE) & ~&busy. all_idle = (state==IDLE) & ~|busy.
//  Reset mid-job: everything returns to reset values next cycle. Engines are reset by the same
//   reset.
// STRUCTURE
//  Shared include md5_defs.vh: BYTE_POS_W=16, CHAR_W=8, scheduler state encodings
//   (IDLE=0, STREAM=1, LOADED=2).
//  Sub-module rr_idle_picker: combinational round-robin first-idle encoder.
//   Inputs busy and rr_ptr; outputs sel and any_idle.
//  Packed vectors use Verilog-2001 indexed part-selects; no SystemVerilog types.
// TESTING
//  1 Reset, job_start with num_bytes=3, bytes A,B,C -> eng_start[0] at t+1;
//    eng_data_valid[0] x3 carrying A,B,C; job_loaded once; busy=0001.
//  2 Four back-to-back jobs, no done -> engines 0,1,2,3 in order; job_ready=0 after 4th;
//    5th job_start ignored.
//  3 eng_done[2] only, then new job with rr_ptr=0 -> dispatched to engine 2; rr_ptr becomes 3.
//  4 eng_done=0110, eng_match=0110 same cycle -> res_engine=1, res_byte_pos=eng_byte_pos[31:16];
//    later match on engine 3 ignored until res_clear.
//  5 res_valid=1, res_engine=1, pulse res_char_next x20 -> only eng_match_char_next[1] toggles;
//    res_char tracks engine-1 char.
//  6 Reset asserted mid-STREAM (count=5 of 10) -> next cycle all outputs 0, busy=0,
//    job_ready=1 after release.

Source files
------------

// File: rtl/md5_engine_scheduler_pkg.sv
// Shared widths and scheduler state encoding for the MD5 engine scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package md5_engine_scheduler_pkg;

    localparam int BYTE_POS_W  = 16;
    localparam int CHAR_W      = 8;
    localparam int NUM_BYTES_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_LOADED = 2'd2
    } sched_state_t;

endpackage

// File: rtl/md5_engine_scheduler_rr_idle_picker.sv
// Round-robin first-idle encoder: searches rr_ptr, rr_ptr+1, ... (mod NUM_ENG) for a non-busy engine.
// Latency: combinational.
// Backpressure: any_idle=0 when every engine is busy; sel is then 0 and must be ignored.
//
// Ports:
//   busy     in   NUM_ENG  per-engine busy flags
//   rr_ptr   in   ENG_W    search start index
//   sel      out  ENG_W    first idle engine at or after rr_ptr
//   any_idle out  1        at least one engine idle
module rr_idle_picker #(
    parameter int NUM_ENG = 4,
    parameter int ENG_W   = 2
) (
    input  logic [NUM_ENG-1:0] busy,
    input  logic [ENG_W-1:0]   rr_ptr,
    output logic [ENG_W-1:0]   sel,
    output logic               any_idle
);

    logic [ENG_W:0]   sum;
    logic [ENG_W-1:0] idx;

    always_comb begin
        sel      = '0;
        any_idle = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            // One extra bit holds rr_ptr+k; a single subtraction wraps it since both are < NUM_ENG.
            sum = {1'b0, rr_ptr} + (ENG_W+1)'(k);
            if (sum >= (ENG_W+1)'(NUM_ENG)) begin
                sum = sum - (ENG_W+1)'(NUM_ENG);
            end
            idx = sum[ENG_W-1:0];
            if (!any_idle && !busy[idx]) begin
                any_idle = 1'b1;
                sel      = idx;
            end
        end
    end

endmodule

// File: rtl/md5_engine_scheduler.sv
// Dispatches jobs round-robin to idle MD5 engines, streams job bytes, latches the first match.
// Latency: eng_start / eng_data / eng_data_valid one cycle after job_start / job_data_valid.
// Backpressure: job_ready low while streaming or when all engines busy; job_start then ignored.
//
// Ports: clk/reset (sync, active-high); job_* from the command parser; res_* to the command
//   layer; eng_* to/from the engine array (packed per-engine vectors); led mirrors busy.
module md5_engine_scheduler
    import md5_engine_scheduler_pkg::*;
#(
    parameter int NUM_ENG = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            job_start,
    input  logic [NUM_BYTES_W-1:0]          job_num_bytes,
    input  logic [CHAR_W-1:0]               job_data,
    input  logic                            job_data_valid,
    output logic                            job_ready,
    output logic                            job_loaded,
    output logic                            all_idle,
    output logic                            res_valid,
    output logic [$clog2(NUM_ENG)-1:0]      res_engine,
    output logic [BYTE_POS_W-1:0]           res_byte_pos,
    output logic [CHAR_W-1:0]               res_char,
    input  logic                            res_char_next,
    input  logic                            res_clear,
    output logic [NUM_ENG-1:0]              eng_start,
    output logic [NUM_BYTES_W-1:0]          eng_num_bytes,
    output logic [CHAR_W-1:0]               eng_data,
    output logic [NUM_ENG-1:0]              eng_data_valid,
    input  logic [NUM_ENG-1:0]              eng_done,
    input  logic [NUM_ENG-1:0]              eng_match,
    input  logic [BYTE_POS_W*NUM_ENG-1:0]   eng_byte_pos,
    input  logic [CHAR_W*NUM_ENG-1:0]       eng_match_char,
    output logic [NUM_ENG-1:0]              eng_match_char_next,
    output logic [NUM_ENG-1:0]              led
);

    localparam int ENG_W = $clog2(NUM_ENG);

    sched_state_t            state, state_nxt;
    logic [ENG_W-1:0]        rr_ptr;
    logic [ENG_W-1:0]        cur_eng;
    logic [ENG_W-1:0]        pick_sel;
    logic                    pick_any;
    logic [NUM_BYTES_W-1:0]  count;
    logic [NUM_ENG-1:0]      busy;
    logic                    dispatch;
    logic                    take_byte;
    logic [NUM_ENG-1:0]      match_vec;
    logic                    hit;
    logic [ENG_W-1:0]        hit_idx;

    rr_idle_picker #(
        .NUM_ENG (NUM_ENG),
        .ENG_W   (ENG_W)
    ) u_picker (
        .busy     (busy),
        .rr_ptr   (rr_ptr),
        .sel      (pick_sel),
        .any_idle (pick_any)
    );

    assign job_ready  = (state == ST_IDLE) && pick_any;
    assign all_idle   = (state == ST_IDLE) && !(|busy);
    assign job_loaded = (state == ST_LOADED);
    assign led        = busy;
    assign dispatch   = (state == ST_IDLE) && job_start && job_ready;
    assign take_byte  = (state == ST_STREAM) && job_data_valid;

    // Read-back path follows whichever engine owns the latched result.
    assign res_char            = res_valid ? eng_match_char[CHAR_W*res_engine +: CHAR_W] : '0;
    assign eng_match_char_next = (res_char_next && res_valid) ? (NUM_ENG'(1) << res_engine) : '0;

    assign match_vec = eng_done & eng_match;
    assign hit       = |match_vec;

    // Descending scan so the lowest matching index is the last (winning) assignment.
    always_comb begin
        hit_idx = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                hit_idx = ENG_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (dispatch) begin
                    state_nxt = (job_num_bytes == '0) ? ST_LOADED : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (job_data_valid && ((count + 1'b1) == eng_num_bytes)) begin
                    state_nxt = ST_LOADED;
                end
            end
            ST_LOADED: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            cur_eng        <= '0;
            count          <= '0;
            busy           <= '0;
            eng_start      <= '0;
            eng_num_bytes  <= '0;
            eng_data       <= '0;
            eng_data_valid <= '0;
            res_valid      <= 1'b0;
            res_engine     <= '0;
            res_byte_pos   <= '0;
        end else begin
            state          <= state_nxt;
            eng_start      <= '0;
            eng_data_valid <= '0;

            if (dispatch) begin
                eng_start     <= NUM_ENG'(1) << pick_sel;
                eng_num_bytes <= job_num_bytes;
                cur_eng       <= pick_sel;
                rr_ptr        <= (pick_sel == ENG_W'(NUM_ENG - 1)) ? '0 : pick_sel + 1'b1;
                count         <= '0;
            end

            if (take_byte) begin
                eng_data       <= job_data;
                eng_data_valid <= NUM_ENG'(1) << cur_eng;
                count          <= count + 1'b1;
            end

            // A done coincident with the start pulse belongs to nothing we launched; keep busy.
            busy <= (busy & ~(eng_done & ~eng_start))
                  | (dispatch ? (NUM_ENG'(1) << pick_sel) : '0);

            if (hit && (!res_valid || res_clear)) begin
                res_valid    <= 1'b1;
                res_engine   <= hit_idx;
                res_byte_pos <= eng_byte_pos[BYTE_POS_W*hit_idx +: BYTE_POS_W];
            end else if (res_clear) begin
                res_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_md5_engine_scheduler.sv
module tb_md5_engine_scheduler;

    logic        clk;
    logic        reset;
    logic        job_start;
    logic [15:0] job_num_bytes;
    logic [7:0]  job_data;
    logic        job_data_valid;
    logic        job_ready;
    logic        job_loaded;
    logic        all_idle;
    logic        res_valid;
    logic [1:0]  res_engine;
    logic [15:0] res_byte_pos;
    logic [7:0]  res_char;
    logic        res_char_next;
    logic        res_clear;
    logic [3:0]  eng_start;
    logic [15:0] eng_num_bytes;
    logic [7:0]  eng_data;
    logic [3:0]  eng_data_valid;
    logic [3:0]  eng_done;
    logic [3:0]  eng_match;
    logic [63:0] eng_byte_pos;
    logic [31:0] eng_match_char;
    logic [3:0]  eng_match_char_next;
    logic [3:0]  led;

    md5_engine_scheduler #(.NUM_ENG(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .job_start           (job_start),
        .job_num_bytes       (job_num_bytes),
        .job_data            (job_data),
        .job_data_valid      (job_data_valid),
        .job_ready           (job_ready),
        .job_loaded          (job_loaded),
        .all_idle            (all_idle),
        .res_valid           (res_valid),
        .res_engine          (res_engine),
        .res_byte_pos        (res_byte_pos),
        .res_char            (res_char),
        .res_char_next       (res_char_next),
        .res_clear           (res_clear),
        .eng_start           (eng_start),
        .eng_num_bytes       (eng_num_bytes),
        .eng_data            (eng_data),
        .eng_data_valid      (eng_data_valid),
        .eng_done            (eng_done),
        .eng_match           (eng_match),
        .eng_byte_pos        (eng_byte_pos),
        .eng_match_char      (eng_match_char),
        .eng_match_char_next (eng_match_char_next),
        .led                 (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] vld;
        logic [7:0] dat;
    } sb_t;

    typedef struct {
        logic [3:0]  done;
        logic [3:0]  match;
        logic        clr;
        logic        exp_v;
        logic [1:0]  exp_e;
        logic [15:0] exp_pos;
        logic [3:0]  exp_led;
    } rvec_t;

    sb_t   sb[$];
    rvec_t tv[6];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle and sample just after the edge; any engine data strobe is scored.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        if (eng_data_valid != 4'b0) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_vld", {28'd0, eng_data_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_vld", {28'd0, eng_data_valid}, {28'd0, e.vld});
                chk("sb_dat", {24'd0, eng_data}, {24'd0, e.dat});
            end
        end
    endtask

    task automatic run_job(input int n, input int exp_eng, input logic [7:0] base);
        job_start     = 1'b1;
        job_num_bytes = 16'(n);
        tick();
        job_start = 1'b0;
        chk("eng_start", {28'd0, eng_start}, 32'd1 << exp_eng);
        chk("eng_num_bytes", {16'd0, eng_num_bytes}, 32'(n));
        for (int i = 0; i < n; i++) begin
            job_data       = base + 8'(i);
            job_data_valid = 1'b1;
            sb.push_back('{vld: 4'(1 << exp_eng), dat: base + 8'(i)});
            tick();
        end
        job_data_valid = 1'b0;
        chk("job_loaded_hi", {31'd0, job_loaded}, 32'd1);
        tick();
        chk("job_loaded_lo", {31'd0, job_loaded}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] ch;

        reset          = 1'b1;
        job_start      = 1'b0;
        job_num_bytes  = 16'd0;
        job_data       = 8'd0;
        job_data_valid = 1'b0;
        res_char_next  = 1'b0;
        res_clear      = 1'b0;
        eng_done       = 4'b0;
        eng_match      = 4'b0;
        eng_byte_pos   = 64'h4444_3333_2222_1111;
        eng_match_char = 32'hD3C2_B1A0;

        // Result-latch vectors applied with all four engines busy.
        tv[0] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b1111};
        tv[1] = '{4'b0110, 4'b0110, 1'b0, 1'b1, 2'd1, 16'h2222, 4'b1001};
        tv[2] = '{4'b1000, 4'b1000, 1'b0, 1'b1, 2'd1, 16'h2222, 4'b0001};
        tv[3] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0000, 4'b0001};
        tv[4] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b0001};
        tv[5] = '{4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 16'h1111, 4'b0000};

        // Reset state.
        tick();
        tick();
        chk("rst_eng_start", {28'd0, eng_start}, 32'd0);
        chk("rst_eng_data_valid", {28'd0, eng_data_valid}, 32'd0);
        chk("rst_eng_num_bytes", {16'd0, eng_num_bytes}, 32'd0);
        chk("rst_eng_data", {24'd0, eng_data}, 32'd0);
        chk("rst_job_loaded", {31'd0, job_loaded}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_char", {24'd0, res_char}, 32'd0);
        chk("rst_match_char_next", {28'd0, eng_match_char_next}, 32'd0);
        chk("rst_led", {28'd0, led}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_job_ready", {31'd0, job_ready}, 32'd1);
        chk("post_rst_all_idle", {31'd0, all_idle}, 32'd1);

        // Single 3-byte job: A, B, C to engine 0.
        run_job(3, 0, 8'h41);
        chk("t1_led", {28'd0, led}, 32'b0001);
        chk("t1_job_ready", {31'd0, job_ready}, 32'd1);
        chk("t1_all_idle", {31'd0, all_idle}, 32'd0);

        // Four back-to-back jobs from a clean reset fill engines 0..3 in order.
        do_reset();
        run_job(1, 0, 8'h10);
        run_job(2, 1, 8'h20);
        run_job(0, 2, 8'h30);
        run_job(1, 3, 8'h40);
        chk("t2_led_full", {28'd0, led}, 32'b1111);
        chk("t2_job_ready", {31'd0, job_ready}, 32'd0);
        job_start     = 1'b1;
        job_num_bytes = 16'd2;
        tick();
        job_start = 1'b0;
        chk("t2_ignored_start", {28'd0, eng_start}, 32'd0);
        tick();
        chk("t2_ignored_loaded", {31'd0, job_loaded}, 32'd0);
        chk("t2_ignored_led", {28'd0, led}, 32'b1111);

        // Engine 2 frees up; with rr_ptr back at 0 the next job must land on engine 2.
        eng_done = 4'b0100;
        tick();
        eng_done = 4'b0000;
        chk("t3_led_after_done", {28'd0, led}, 32'b1011);
        chk("t3_job_ready", {31'd0, job_ready}, 32'd1);
        run_job(1, 2, 8'h50);
        // Free 0 and 3: rr_ptr should now be 3, so engine 3 is chosen over 0.
        eng_done = 4'b1001;
        tick();
        eng_done = 4'b0000;
        run_job(0, 3, 8'h00);
        chk("t3_led", {28'd0, led}, 32'b1110);

        // Start and done on the same engine in the same cycle: busy must hold.
        job_start     = 1'b1;
        job_num_bytes = 16'd0;
        tick();
        job_start = 1'b0;
        chk("sd_eng_start", {28'd0, eng_start}, 32'b0001);
        eng_done = 4'b0001;
        tick();
        eng_done = 4'b0000;
        chk("sd_led", {28'd0, led}, 32'b1111);
        chk("sd_job_ready", {31'd0, job_ready}, 32'd0);

        // Result-latch table.
        for (int i = 0; i < 6; i++) begin
            eng_done  = tv[i].done;
            eng_match = tv[i].match;
            res_clear = tv[i].clr;
            tick();
            eng_done  = 4'b0;
            eng_match = 4'b0;
            res_clear = 1'b0;
            chk($sformatf("tv%0d_res_valid", i), {31'd0, res_valid}, {31'd0, tv[i].exp_v});
            if (tv[i].exp_v) begin
                chk($sformatf("tv%0d_res_engine", i), {30'd0, res_engine}, {30'd0, tv[i].exp_e});
                chk($sformatf("tv%0d_res_byte_pos", i), {16'd0, res_byte_pos}, {16'd0, tv[i].exp_pos});
            end
            chk($sformatf("tv%0d_led", i), {28'd0, led}, {28'd0, tv[i].exp_led});
        end
        chk("tv_all_idle", {31'd0, all_idle}, 32'd1);

        // Matched-string read-back from engine 1.
        run_job(0, 1, 8'h00);
        eng_done  = 4'b0010;
        eng_match = 4'b0010;
        res_clear = 1'b1;
        tick();
        eng_done  = 4'b0;
        eng_match = 4'b0;
        res_clear = 1'b0;
        chk("rd_res_engine", {30'd0, res_engine}, 32'd1);
        chk("rd_res_byte_pos", {16'd0, res_byte_pos}, 32'h2222);
        for (int k = 0; k < 20; k++) begin
            ch             = 8'($urandom);
            eng_match_char = $urandom;
            eng_match_char[15:8] = ch;
            res_char_next  = 1'b1;
            #1;
            chk("rd_next_hi", {28'd0, eng_match_char_next}, 32'b0010);
            chk("rd_res_char", {24'd0, res_char}, {24'd0, ch});
            tick();
            res_char_next = 1'b0;
            #1;
            chk("rd_next_lo", {28'd0, eng_match_char_next}, 32'd0);
        end

        // Reset in the middle of a 10-byte stream (5 bytes forwarded).
        job_start     = 1'b1;
        job_num_bytes = 16'd10;
        tick();
        job_start = 1'b0;
        chk("mr_eng_start", {28'd0, eng_start}, 32'b0100);
        for (int i = 0; i < 5; i++) begin
            job_data       = 8'h60 + 8'(i);
            job_data_valid = 1'b1;
            sb.push_back('{vld: 4'b0100, dat: 8'h60 + 8'(i)});
            tick();
        end
        job_data       = 8'h65;
        reset          = 1'b1;
        tick();
        job_data_valid = 1'b0;
        chk("mr_eng_data_valid", {28'd0, eng_data_valid}, 32'd0);
        chk("mr_eng_data", {24'd0, eng_data}, 32'd0);
        chk("mr_eng_num_bytes", {16'd0, eng_num_bytes}, 32'd0);
        chk("mr_res_valid", {31'd0, res_valid}, 32'd0);
        chk("mr_led", {28'd0, led}, 32'd0);
        chk("mr_job_loaded", {31'd0, job_loaded}, 32'd0);
        reset = 1'b0;
        tick();
        chk("mr_job_ready", {31'd0, job_ready}, 32'd1);
        chk("mr_all_idle", {31'd0, all_idle}, 32'd1);
        tick();
        chk("mr_no_stray_vld", {28'd0, eng_data_valid}, 32'd0);
        chk("sb_final_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
